mem_stage: RTL and testbench

//  MIPS32 memory-access stage; sits between EX and WB. Accepts one EX/MEM op per

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/mem_stage_if.sv | 39 +++
 rtl/mem_stage_data_mem.sv | 26 ++
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and lane helpers for the MIPS32 memory stage
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        mem_size_e   size;
        logic        uns;
    } mem_op_t;

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input mem_size_e size, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: return uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] lane, input mem_size_e size);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM input bundle and MEM/WB output bundle of the memory stage
interface mem_stage_if;
    import mips_pkg::*;

    logic        ex_valid;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_MemtoReg;
    logic        ex_RegWrite;
    logic [31:0] ex_aluResult;
    logic [31:0] ex_writeData;
    logic [4:0]  ex_writeReg;
    mem_size_e   ex_memSize;
    logic        ex_memUnsigned;

    logic        mem_stall;
    logic        wb_valid;
    logic        wb_MemtoReg;
    logic        wb_RegWrite;
    logic [31:0] wb_readData;
    logic [31:0] wb_aluOut;
    logic [4:0]  wb_writeReg;
    logic        mem_misalign;

    modport master (
        output ex_valid, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite,
               ex_aluResult, ex_writeData, ex_writeReg, ex_memSize, ex_memUnsigned,
        input  mem_stall, wb_valid, wb_MemtoReg, wb_RegWrite, wb_readData,
               wb_aluOut, wb_writeReg, mem_misalign
    );

    modport slave (
        input  ex_valid, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite,
               ex_aluResult, ex_writeData, ex_writeReg, ex_memSize, ex_memUnsigned,
        output mem_stall, wb_valid, wb_MemtoReg, wb_RegWrite, wb_readData,
               wb_aluOut, wb_writeReg, mem_misalign
    );

endinterface

// File: rtl/mem_stage_data_mem.sv
// rtl/mem_stage_data_mem.sv - single-port data memory, async read, sync byte-enabled write
module data_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS32 MEM stage with wait-state FSM; MEM_SUBWORD_EN enables byte/half access
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int MEM_LATENCY = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    mem_stage_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

    mem_state_e  state_q;
    logic [3:0]  cnt_q;
    mem_op_t     op_q;
    mem_op_t     ex_op;
    mem_op_t     cur_op;
    logic        defer;
    logic        do_access;
    logic        misalign;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;

    logic        wb_valid_q, wb_memtoreg_q, wb_regwrite_q, misalign_q;
    logic [31:0] wb_readdata_q, wb_aluout_q;
    logic [4:0]  wb_writereg_q;

    always_comb begin
        ex_op            = '0;
        ex_op.mem_read   = bus.ex_MemRead;
        ex_op.mem_write  = bus.ex_MemWrite;
        ex_op.mem_to_reg = bus.ex_MemtoReg;
        ex_op.reg_write  = bus.ex_RegWrite;
        ex_op.addr       = bus.ex_aluResult;
        ex_op.wdata      = bus.ex_writeData;
        ex_op.wreg       = bus.ex_writeReg;
        ex_op.size       = bus.ex_memSize;
        ex_op.uns        = bus.ex_memUnsigned;
    end

    // In WAIT the upstream bundle is don't-care; the latched op drives the access.
    assign cur_op    = (state_q == WAIT) ? op_q : ex_op;
    assign defer     = (bus.ex_MemRead | bus.ex_MemWrite) && (MEM_LATENCY != 0);
    assign do_access = (state_q == IDLE) ? (bus.ex_valid && !defer) : (cnt_q == 4'd0);
    assign bus.mem_stall = (state_q == IDLE) ? (bus.ex_valid && defer) : (cnt_q != 4'd0);

`ifdef MEM_SUBWORD_EN
    logic unused_addr_hi;
    assign unused_addr_hi = ^cur_op.addr[31:AW+2];
    assign misalign = (cur_op.mem_read | cur_op.mem_write) &&
                      ((cur_op.size == SZ_HALF) ? cur_op.addr[0] :
                       ((cur_op.size != SZ_BYTE) && (cur_op.addr[1:0] != 2'b00)));
    assign mem_be    = lane_enables(cur_op.addr[1:0], cur_op.size);
    assign load_data = load_extend(mem_rdata, cur_op.addr[1:0], cur_op.size, cur_op.uns);
    always_comb begin
        case (cur_op.size)
            SZ_BYTE: mem_wdata = {4{cur_op.wdata[7:0]}};
            SZ_HALF: mem_wdata = {2{cur_op.wdata[15:0]}};
            default: mem_wdata = cur_op.wdata;
        endcase
    end
`else
    logic unused_fields;
    assign unused_fields = ^{cur_op.addr[31:AW+2], cur_op.addr[1:0], cur_op.size, cur_op.uns};
    assign misalign  = 1'b0;
    assign mem_be    = 4'b1111;
    assign mem_wdata = cur_op.wdata;
    assign load_data = mem_rdata;
`endif

    assign mem_we = do_access && cur_op.mem_write && !misalign;

    data_mem #(.DEPTH(DEPTH), .AW(AW)) u_data_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .addr_i  (cur_op.addr[AW+1:2]),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            op_q          <= '0;
            wb_valid_q    <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_readdata_q <= 32'd0;
            wb_aluout_q   <= 32'd0;
            wb_writereg_q <= 5'd0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (do_access) begin
                wb_valid_q    <= 1'b1;
                wb_memtoreg_q <= cur_op.mem_to_reg;
                wb_regwrite_q <= cur_op.reg_write && !misalign;
                wb_readdata_q <= (cur_op.mem_read && !misalign) ? load_data : 32'd0;
                wb_aluout_q   <= cur_op.addr;
                wb_writereg_q <= cur_op.wreg;
                misalign_q    <= misalign;
            end else begin
                wb_valid_q    <= 1'b0;
                wb_regwrite_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (bus.ex_valid && defer) begin
                        op_q    <= ex_op;
                        cnt_q   <= LAT_M1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_q <= IDLE;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
            endcase
        end
    end

    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_MemtoReg  = wb_memtoreg_q;
    assign bus.wb_RegWrite  = wb_regwrite_q;
    assign bus.wb_readData  = wb_readdata_q;
    assign bus.wb_aluOut    = wb_aluout_q;
    assign bus.wb_writeReg  = wb_writereg_q;
    assign bus.mem_misalign = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage at latency 0 and 3
module tb_mem_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        m2r;
        logic        rw;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    wb_t q0[$];
    wb_t q3[$];
    logic [31:0] mdl0 [16];
    logic [31:0] mdl3 [16];

    logic        v0 = 1'b0, v3 = 1'b0;
    logic        ex_mr = 1'b0, ex_mw = 1'b0, ex_m2r = 1'b0, ex_rw = 1'b0, ex_uns = 1'b0;
    logic [31:0] ex_addr = '0, ex_wd = '0;
    logic [4:0]  ex_wreg = '0;
    mem_size_e   ex_sz = SZ_WORD;

    mem_stage_if b0();
    mem_stage_if b3();

    assign b0.ex_valid = v0;               assign b3.ex_valid = v3;
    assign b0.ex_MemRead = ex_mr;          assign b3.ex_MemRead = ex_mr;
    assign b0.ex_MemWrite = ex_mw;         assign b3.ex_MemWrite = ex_mw;
    assign b0.ex_MemtoReg = ex_m2r;        assign b3.ex_MemtoReg = ex_m2r;
    assign b0.ex_RegWrite = ex_rw;         assign b3.ex_RegWrite = ex_rw;
    assign b0.ex_aluResult = ex_addr;      assign b3.ex_aluResult = ex_addr;
    assign b0.ex_writeData = ex_wd;        assign b3.ex_writeData = ex_wd;
    assign b0.ex_writeReg = ex_wreg;       assign b3.ex_writeReg = ex_wreg;
    assign b0.ex_memSize = ex_sz;          assign b3.ex_memSize = ex_sz;
    assign b0.ex_memUnsigned = ex_uns;     assign b3.ex_memUnsigned = ex_uns;

    mem_stage #(.DEPTH(16), .MEM_LATENCY(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    mem_stage #(.DEPTH(16), .MEM_LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    function automatic wb_t obs0();
        return {b0.wb_readData, b0.wb_aluOut, b0.wb_writeReg, b0.wb_MemtoReg, b0.wb_RegWrite};
    endfunction

    function automatic wb_t obs3();
        return {b3.wb_readData, b3.wb_aluOut, b3.wb_writeReg, b3.wb_MemtoReg, b3.wb_RegWrite};
    endfunction

    task automatic set_op(input logic mr, mw, m2r, rw, input logic [31:0] addr, wd,
                          input logic [4:0] wreg, input mem_size_e sz, input logic uns);
        ex_mr = mr; ex_mw = mw; ex_m2r = m2r; ex_rw = rw;
        ex_addr = addr; ex_wd = wd; ex_wreg = wreg; ex_sz = sz; ex_uns = uns;
    endtask

    // Word-access reference: load sees the old word, store updates afterwards.
    task automatic model_push(input int d);
        logic [3:0] idx;
        wb_t e;
        idx   = ex_addr[5:2];
        e.rd  = ex_mr ? ((d == 0) ? mdl0[idx] : mdl3[idx]) : 32'd0;
        e.alu = ex_addr;
        e.wr  = ex_wreg;
        e.m2r = ex_m2r;
        e.rw  = ex_rw;
        if (ex_mw) begin
            if (d == 0) mdl0[idx] = ex_wd;
            else        mdl3[idx] = ex_wd;
        end
        if (d == 0) q0.push_back(e);
        else        q3.push_back(e);
    endtask

    task automatic step0(input logic mr, mw, rw, input logic [31:0] addr, wd, input logic [4:0] wreg);
        set_op(mr, mw, mr, rw, addr, wd, wreg, SZ_WORD, 1'b0);
        v0 = 1'b1;
        model_push(0);
        @(posedge clk); #1;
    endtask

    task automatic step3(input logic mr, mw, rw, input logic [31:0] addr, wd, input logic [4:0] wreg,
                         output int stalls, output logic vb);
        set_op(mr, mw, mr, rw, addr, wd, wreg, SZ_WORD, 1'b0);
        v3 = 1'b1;
        model_push(1);
        stalls = 0;
        @(negedge clk);
        while (b3.mem_stall && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        vb = b3.wb_valid;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        v0 = 1'b0; v3 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (b0.wb_valid !== 1'b0) begin failures++; $display("FAIL rst_valid0 got=%b exp=0", b0.wb_valid); end
        checks++; if (obs0() !== '0) begin failures++; $display("FAIL rst_bundle0 got=%h exp=0", obs0()); end
        checks++; if (b0.mem_misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", b0.mem_misalign); end
        checks++; if (b0.mem_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", b0.mem_stall); end
        checks++; if (b3.wb_valid !== 1'b0) begin failures++; $display("FAIL rst_valid3 got=%b exp=0", b3.wb_valid); end
        checks++; if (obs3() !== '0) begin failures++; $display("FAIL rst_bundle3 got=%h exp=0", obs3()); end
    endtask

    task automatic test_store_load();
        wb_t e;
        step0(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        e = q0.pop_front();
        checks++; if (b0.wb_valid !== 1'b1) begin failures++; $display("FAIL sw_valid got=%b exp=1", b0.wb_valid); end
        checks++; if (obs0() !== e) begin failures++; $display("FAIL sw_bundle got=%h exp=%h", obs0(), e); end
        step0(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd5);
        e = q0.pop_front();
        checks++; if (b0.wb_readData !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", b0.wb_readData); end
        checks++; if (obs0() !== e) begin failures++; $display("FAIL lw_bundle got=%h exp=%h", obs0(), e); end
        idle();
        checks++; if (b0.wb_valid !== 1'b0 || b0.wb_RegWrite !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%b%b exp=00", b0.wb_valid, b0.wb_RegWrite); end
        checks++; if (b0.wb_aluOut !== 32'h10) begin failures++; $display("FAIL bubble_hold got=%h exp=10", b0.wb_aluOut); end
    endtask

    task automatic test_alias_rmw();
        wb_t e;
        step0(1'b0, 1'b1, 1'b0, 32'd8, 32'h12345678, 5'd1);
        e = q0.pop_front();
        checks++; if (obs0() !== e) begin failures++; $display("FAIL alias_sw got=%h exp=%h", obs0(), e); end
        step0(1'b1, 1'b0, 1'b1, 32'd72, 32'h0, 5'd2);
        e = q0.pop_front();
        checks++; if (b0.wb_readData !== 32'h12345678) begin failures++; $display("FAIL alias_lw got=%h exp=12345678", b0.wb_readData); end
        checks++; if (obs0() !== e) begin failures++; $display("FAIL alias_bundle got=%h exp=%h", obs0(), e); end
        step0(1'b1, 1'b1, 1'b1, 32'h10, 32'h55, 5'd3);
        e = q0.pop_front();
        checks++; if (b0.wb_readData !== 32'hDEADBEEF) begin failures++; $display("FAIL rmw_old got=%h exp=deadbeef", b0.wb_readData); end
        step0(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd4);
        e = q0.pop_front();
        checks++; if (b0.wb_readData !== 32'h55) begin failures++; $display("FAIL rmw_new got=%h exp=55", b0.wb_readData); end
        idle();
    endtask

    task automatic test_back_to_back();
        wb_t e;
        for (int i = 0; i < 16; i++) begin
            step0(1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom, 5'(i));
            e = q0.pop_front();
            checks++; if (b0.wb_valid !== 1'b1 || obs0() !== e) begin failures++; $display("FAIL b2b_fill%0d got=%b/%h exp=1/%h", i, b0.wb_valid, obs0(), e); end
        end
        for (int i = 0; i < 40; i++) begin
            step0(1'($urandom), 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom));
            e = q0.pop_front();
            checks++; if (b0.wb_valid !== 1'b1 || obs0() !== e) begin failures++; $display("FAIL b2b_rand%0d got=%b/%h exp=1/%h", i, b0.wb_valid, obs0(), e); end
        end
        idle();
    endtask

    task automatic test_latency();
        wb_t e;
        int st;
        logic vb;
        step3(1'b0, 1'b1, 1'b0, 32'h20, 32'h11111111, 5'd0, st, vb);
        e = q3.pop_front();
        checks++; if (st !== 3) begin failures++; $display("FAIL lat_sw_stalls got=%0d exp=3", st); end
        checks++; if (b3.wb_valid !== 1'b1 || obs3() !== e) begin failures++; $display("FAIL lat_sw got=%b/%h exp=1/%h", b3.wb_valid, obs3(), e); end
        step3(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd7, st, vb);
        e = q3.pop_front();
        checks++; if (st !== 3) begin failures++; $display("FAIL lat_lw_stalls got=%0d exp=3", st); end
        checks++; if (vb !== 1'b0) begin failures++; $display("FAIL lat_lw_early got=%b exp=0", vb); end
        checks++; if (b3.wb_readData !== 32'h11111111 || obs3() !== e) begin failures++; $display("FAIL lat_lw got=%h exp=%h", obs3(), e); end
        step3(1'b0, 1'b0, 1'b1, 32'hABCD0000, 32'h0, 5'd9, st, vb);
        e = q3.pop_front();
        checks++; if (st !== 0) begin failures++; $display("FAIL rtype_stalls got=%0d exp=0", st); end
        checks++; if (b3.wb_valid !== 1'b1 || b3.wb_aluOut !== 32'hABCD0000 || obs3() !== e) begin failures++; $display("FAIL rtype got=%b/%h exp=1/%h", b3.wb_valid, obs3(), e); end
        idle();
    endtask

    task automatic test_reset_wait();
        wb_t e;
        int st;
        logic vb;
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h22222222, 5'd4, SZ_WORD, 1'b0);
        v3 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0; v3 = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (b3.mem_stall !== 1'b0 || b3.wb_valid !== 1'b0) begin failures++; $display("FAIL rstw_state got=%b%b exp=00", b3.mem_stall, b3.wb_valid); end
        checks++; if (obs3() !== '0) begin failures++; $display("FAIL rstw_bundle got=%h exp=0", obs3()); end
        step3(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd8, st, vb);
        e = q3.pop_front();
        checks++; if (st !== 3) begin failures++; $display("FAIL rstw_stalls got=%0d exp=3", st); end
        checks++; if (b3.wb_readData !== 32'h11111111 || obs3() !== e) begin failures++; $display("FAIL rstw_word got=%h exp=%h", obs3(), e); end
        idle();
    endtask

`ifdef MEM_SUBWORD_EN
    task automatic test_subword();
        v0 = 1'b1;
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h80FF1234, 5'd0, SZ_WORD, 1'b0);
        @(posedge clk); #1;
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'd3, 32'd0, 5'd6, SZ_BYTE, 1'b0);
        @(posedge clk); #1;
        checks++; if (b0.wb_readData !== 32'hFFFFFF80) begin failures++; $display("FAIL sub_lb got=%h exp=ffffff80", b0.wb_readData); end
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 32'd0, 5'd6, SZ_HALF, 1'b1);
        @(posedge clk); #1;
        checks++; if (b0.wb_readData !== 32'h000080FF) begin failures++; $display("FAIL sub_lhu got=%h exp=000080ff", b0.wb_readData); end
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'h000000AA, 5'd0, SZ_BYTE, 1'b0);
        @(posedge clk); #1;
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 5'd6, SZ_WORD, 1'b0);
        @(posedge clk); #1;
        checks++; if (b0.wb_readData !== 32'h80FFAA34) begin failures++; $display("FAIL sub_sb got=%h exp=80ffaa34", b0.wb_readData); end
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 32'd0, 5'd6, SZ_WORD, 1'b0);
        @(posedge clk); #1;
        checks++; if (b0.mem_misalign !== 1'b1 || b0.wb_RegWrite !== 1'b0 || b0.wb_valid !== 1'b1) begin failures++; $display("FAIL sub_mis got=%b%b%b exp=101", b0.mem_misalign, b0.wb_RegWrite, b0.wb_valid); end
        checks++; if (b0.wb_readData !== 32'd0) begin failures++; $display("FAIL sub_mis_data got=%h exp=0", b0.wb_readData); end
        idle();
        checks++; if (b0.mem_misalign !== 1'b0) begin failures++; $display("FAIL sub_mis_pulse got=%b exp=0", b0.mem_misalign); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_alias_rmw();
        test_back_to_back();
        test_latency();
        test_reset_wait();
`ifdef MEM_SUBWORD_EN
        test_subword();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
